// File: rtl/multi_mode_ff_pkg.sv
// Shared definitions for the multi-mode flip-flop bank: mode encodings and
// the single-bit next-state rule used by every cell.
package multi_mode_ff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_SR = 2'b01;
  localparam mode_t MODE_D  = 2'b10;
  localparam mode_t MODE_T  = 2'b11;

  // a acts as J/S/D/T and b as K/R; the illegal SR case holds the bit.
  function automatic logic next_state(input mode_t mode, input logic a,
                                      input logic b, input logic q);
    logic q_next;
    q_next = q;
    case (mode)
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      default: q_next = q ^ a;
    endcase
    return q_next;
  endfunction

endpackage

// File: rtl/multi_mode_ff_reg_ff_cell.sv
// One bit of the bank: next-state selection (load > en > hold) plus storage,
// and a flag marking an illegal SR request on this bit.
module ff_cell
  import multi_mode_ff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  input  logic  load,
  input  logic  load_val,
  output logic  q,
  output logic  q_next,
  output logic  illegal_sr
);

  logic r_q;

  assign q_next = load ? load_val
                : en   ? next_state(mode, a, b, r_q)
                :        r_q;

  // A load on the same edge masks the illegal request entirely.
  assign illegal_sr = ~load & en & (mode == MODE_SR) & a & b;

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RESET_BIT;
    else        r_q <= q_next;
  end

  assign q = r_q;

endmodule

// File: rtl/multi_mode_ff_reg.sv
// WIDTH-bit bank of flip-flops with run-time selectable JK/SR/D/T semantics,
// parallel load, per-bit change flags and a sticky illegal-SR error.
module multi_mode_ff_reg
  import multi_mode_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] changed,
  output logic             sr_err
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_illegal;
  logic [WIDTH-1:0] r_changed;
  logic             r_sr_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_BIT(RESET_VAL[i])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst),
      .en        (en),
      .mode      (mode),
      .a         (a[i]),
      .b         (b[i]),
      .load      (load),
      .load_val  (load_val[i]),
      .q         (w_q[i]),
      .q_next    (w_q_next[i]),
      .illegal_sr(w_illegal[i])
    );
  end

  // Setting takes precedence over err_clr on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_changed <= '0;
      r_sr_err  <= 1'b0;
    end else begin
      r_changed <= w_q_next ^ w_q;
      if (|w_illegal)   r_sr_err <= 1'b1;
      else if (err_clr) r_sr_err <= 1'b0;
    end
  end

  assign q       = w_q;
  assign q_bar   = ~w_q;
  assign changed = r_changed;
  assign sr_err  = r_sr_err;

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Self-checking bench: three bank widths driven with shared directed vectors,
// checked every cycle against a bit-loop model plus hand-computed literals.
module tb_multi_mode_ff_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        load = 1'b0;
  logic [31:0] load_val = '0;
  logic        err_clr = 1'b0;

  logic [7:0]  q8, qb8, ch8;
  logic [0:0]  q1, qb1, ch1;
  logic [31:0] q32, qb32, ch32;
  logic        e8, e1, e32;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_mode_ff_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .load(load), .load_val(load_val[7:0]), .err_clr(err_clr),
    .q(q8), .q_bar(qb8), .changed(ch8), .sr_err(e8));

  multi_mode_ff_reg #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a[0:0]), .b(b[0:0]),
    .load(load), .load_val(load_val[0:0]), .err_clr(err_clr),
    .q(q1), .q_bar(qb1), .changed(ch1), .sr_err(e1));

  multi_mode_ff_reg #(.WIDTH(32), .RESET_VAL(32'hFFFF_FFFF)) dut32 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .err_clr(err_clr),
    .q(q32), .q_bar(qb32), .changed(ch32), .sr_err(e32));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state, index 0: WIDTH 8, 1: WIDTH 1, 2: WIDTH 32.
  int          mw [3] = '{8, 1, 32};
  logic [31:0] mrv[3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
  logic [31:0] mq [3];
  logic [31:0] mch[3];
  logic        merr[3];

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  task automatic model_step(input int k);
    logic [31:0] nq;
    logic        bad;
    nq  = mq[k];
    bad = 1'b0;
    if (load) begin
      nq = load_val & mask_of(mw[k]);
    end else if (en) begin
      for (int i = 0; i < mw[k]; i++) begin
        if (mode == 2'b10) nq[i] = a[i];
        else if (mode == 2'b11) nq[i] = mq[k][i] ^ a[i];
        else if (a[i] && b[i]) begin
          if (mode == 2'b00) nq[i] = ~mq[k][i];
          else bad = 1'b1;
        end
        else if (a[i]) nq[i] = 1'b1;
        else if (b[i]) nq[i] = 1'b0;
      end
    end
    mch[k] = nq ^ mq[k];
    if (bad) merr[k] = 1'b1;
    else if (err_clr) merr[k] = 1'b0;
    mq[k] = nq;
  endtask

  // Single compare process: advance model on each edge, compare 1 ns later.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mq[k] = mrv[k]; mch[k] = '0; merr[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
    #1;
    check("w8 q",        {24'h0, q8},   mq[0]);
    check("w8 q_bar",    {24'h0, qb8},  ~mq[0] & mask_of(8));
    check("w8 changed",  {24'h0, ch8},  mch[0]);
    check("w8 sr_err",   {31'h0, e8},   {31'h0, merr[0]});
    check("w1 q",        {31'h0, q1},   mq[1]);
    check("w1 q_bar",    {31'h0, qb1},  ~mq[1] & mask_of(1));
    check("w1 changed",  {31'h0, ch1},  mch[1]);
    check("w1 sr_err",   {31'h0, e1},   {31'h0, merr[1]});
    check("w32 q",       q32,           mq[2]);
    check("w32 q_bar",   qb32,          ~mq[2]);
    check("w32 changed", ch32,          mch[2]);
    check("w32 sr_err",  {31'h0, e32},  {31'h0, merr[2]});
  end

  // Apply one vector just after a falling edge and return at the next one.
  task automatic drive(input logic l, input logic [31:0] lv, input logic e,
                       input logic [1:0] m, input logic [31:0] ai,
                       input logic [31:0] bi, input logic ec);
    load = l; load_val = lv; en = e; mode = m; a = ai; b = bi; err_clr = ec;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("lit w32 reset q", q32, 32'hFFFF_FFFF);
    check("lit w1 reset q",  {31'h0, q1}, 32'h1);

    // JK
    drive(0, 0, 1, 2'b00, 32'h0000_00F0, 32'h0000_000F, 0);
    check("lit jk set/reset q", {24'h0, q8}, 32'hF0);
    drive(0, 0, 1, 2'b00, 32'h0000_00FF, 32'h0000_00FF, 0);
    check("lit jk toggle q",    {24'h0, q8},  32'h0F);
    check("lit jk toggle chg",  {24'h0, ch8}, 32'hFF);
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    check("lit jk hold q",      {24'h0, q8},  32'h0F);
    check("lit jk hold chg",    {24'h0, ch8}, 32'h00);

    // SR and sticky error
    drive(0, 0, 1, 2'b01, 32'h0000_0030, 32'h0000_0003, 0);
    check("lit sr q",           {24'h0, q8}, 32'h3C);
    drive(0, 0, 1, 2'b01, 32'h0000_0001, 32'h0000_0001, 0);
    check("lit sr illegal q",   {24'h0, q8}, 32'h3C);
    check("lit sr illegal err", {31'h0, e8}, 32'h1);
    drive(0, 0, 1, 2'b01, 32'h0000_0002, 32'h0000_0002, 1);
    check("lit set beats clr",  {31'h0, e8}, 32'h1);
    drive(0, 0, 1, 2'b01, 32'h0, 32'h0, 1);
    check("lit err cleared",    {31'h0, e8}, 32'h0);

    // D, T, enable off
    drive(0, 0, 1, 2'b10, 32'h0000_00A5, 32'h0, 0);
    check("lit d q",            {24'h0, q8},  32'hA5);
    drive(0, 0, 1, 2'b11, 32'h0000_000F, 32'h0, 0);
    check("lit t q",            {24'h0, q8},  32'hAA);
    check("lit t chg",          {24'h0, ch8}, 32'h0F);
    drive(0, 0, 0, 2'b11, 32'hFFFF_FFFF, 32'h0, 0);
    check("lit en off q",       {24'h0, q8},  32'hAA);

    // Load beats enable and suppresses the SR error
    drive(1, 32'h0000_005A, 1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("lit load q",         {24'h0, q8}, 32'h5A);
    check("lit load no err",    {31'h0, e8}, 32'h0);

    // Mid-cycle asynchronous reset with pending load and err_clr
    drive(0, 0, 1, 2'b01, 32'h0000_0080, 32'h0000_0080, 0);
    check("lit pre-reset err",  {31'h0, e8}, 32'h1);
    load = 1'b1; load_val = 32'h0000_0033; err_clr = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("lit async q",        {24'h0, q8},  32'h00);
    check("lit async q_bar",    {24'h0, qb8}, 32'hFF);
    check("lit async chg",      {24'h0, ch8}, 32'h00);
    check("lit async err",      {31'h0, e8},  32'h0);
    check("lit async w32 q",    q32,          32'hFFFF_FFFF);
    @(negedge clk);
    load = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Width sweep: toggle bit 0 and bit 31 from the all-ones reset value
    drive(0, 0, 1, 2'b00, 32'h8000_0001, 32'h8000_0001, 0);
    check("lit w32 toggle q",   q32,          32'h7FFF_FFFE);
    check("lit w32 toggle chg", ch32,         32'h8000_0001);
    check("lit w1 toggle q",    {31'h0, q1},  32'h0);
    check("lit w8 bit0 q",      {24'h0, q8},  32'h01);
    drive(0, 0, 1, 2'b00, 32'h8000_0001, 32'h8000_0001, 0);
    check("lit w32 toggle2 q",  q32,          32'hFFFF_FFFF);
    check("lit w1 toggle2 q",   {31'h0, q1},  32'h1);
    drive(0, 0, 1, 2'b00, 32'h0, 32'h8000_0000, 0);
    check("lit w32 msb reset",  q32,          32'h7FFF_FFFF);
    drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
